// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between the two ALU operand requesters and the mux arbiter.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface mux2_arbiter_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;

    modport master (
        output req0,
        output req1,
        input  gnt0,
        input  gnt1,
        input  sel,
        input  busy
    );

    modport slave (
        input  req0,
        input  req1,
        output gnt0,
        output gnt1,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin owner of the ALU operand mux select line, with a burst limit
// that bounds how long one requester may hold the mux while the other waits.
module mux2_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux2_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_sel;
    logic             w_sel_nxt;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic             w_burst_done;
    logic             w_enter;

    assign w_burst_done = (r_cnt == CNT_LAST);

    // Next owner: round-robin on ties, direct handover on release or burst expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_state_nxt = r_last ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    w_state_nxt = OWN0;
                end else if (bus.req1) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    w_state_nxt = bus.req1 ? OWN1 : IDLE;
                end else if (bus.req1 && w_burst_done) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    w_state_nxt = bus.req0 ? OWN0 : IDLE;
                end else if (bus.req0 && w_burst_done) begin
                    w_state_nxt = OWN0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Burst counter, last-served and select follow the next owner; sel holds through IDLE
    always_comb begin
        w_cnt_nxt  = '0;
        w_last_nxt = r_last;
        w_sel_nxt  = r_sel;
        w_enter    = (w_state_nxt != IDLE) && (w_state_nxt != r_state);
        if (w_enter) begin
            w_last_nxt = (w_state_nxt == OWN1);
            w_sel_nxt  = (w_state_nxt == OWN1);
        end else if (w_state_nxt != IDLE) begin
            w_cnt_nxt = w_burst_done ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt0  <= (w_state_nxt == OWN0);
            r_gnt1  <= (w_state_nxt == OWN1);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign bus.gnt0 = r_gnt0;
    assign bus.gnt1 = r_gnt1;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: two instances (MAX_BURST=4 and 1) share
// the same request stimulus and are checked against a behavioural owner model.
module tb_mux2_arbiter;

    localparam int MB0 = 4;
    localparam int MB1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mux2_arbiter_if u_if4 ();
    mux2_arbiter_if u_if1 ();

    mux2_arbiter #(.MAX_BURST(MB0)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4.slave));
    mux2_arbiter #(.MAX_BURST(MB1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model per instance: owner -1 none / 0 / 1, cycles held, last served, mux select
    int   m_owner [2];
    int   m_run   [2];
    int   m_last  [2];
    logic m_sel   [2];

    logic [3:0] q_exp4[$];
    logic [3:0] q_exp1[$];

    logic cur_a = 1'b0;
    logic cur_b = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_run[k]   = 0;
            m_last[k]  = 1;
            m_sel[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic a, input logic b);
        int   lim;
        int   o;
        int   nw;
        logic r_own;
        logic r_oth;
        lim = (k == 0) ? MB0 : MB1;
        o   = m_owner[k];
        if (o < 0) begin
            if (a && b)  nw = 1 - m_last[k];
            else if (a)  nw = 0;
            else if (b)  nw = 1;
            else         nw = -1;
        end else begin
            r_own = (o == 0) ? a : b;
            r_oth = (o == 0) ? b : a;
            if (!r_own)                      nw = r_oth ? 1 - o : -1;
            else if (r_oth && m_run[k] >= lim) nw = 1 - o;
            else                             nw = o;
        end
        if (nw >= 0 && nw != o) begin
            m_run[k]  = 1;
            m_last[k] = nw;
            m_sel[k]  = (nw == 1);
        end else if (nw >= 0) begin
            m_run[k] = m_run[k] + 1;
        end else begin
            m_run[k] = 0;
        end
        m_owner[k] = nw;
    endtask

    function automatic logic [3:0] model_out(input int k);
        return {m_owner[k] == 0, m_owner[k] == 1, m_sel[k], m_owner[k] >= 0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got {gnt0,gnt1,sel,busy}=%b want %b", name, $time, act, exp);
    endtask

    // Drive requests away from the edge and queue the outputs expected after the next edge
    task automatic apply(input logic a, input logic b);
        cur_a = a;
        cur_b = b;
        u_if4.req0 = a;
        u_if4.req1 = b;
        u_if1.req0 = a;
        u_if1.req1 = b;
        model_step(0, a, b);
        model_step(1, a, b);
        q_exp4.push_back(model_out(0));
        q_exp1.push_back(model_out(1));
    endtask

    task automatic cyc(input logic a, input logic b);
        @(posedge clk);
        #2;
        apply(a, b);
    endtask

    task automatic cycn(input int n, input logic a, input logic b);
        for (int i = 0; i < n; i++) cyc(a, b);
    endtask

    // Async reset pulse: outputs must clear without waiting for an edge
    task automatic do_reset(input logic a, input logic b);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mb4", {u_if4.gnt0, u_if4.gnt1, u_if4.sel, u_if4.busy}, 4'b0000);
        check("async_reset_mb1", {u_if1.gnt0, u_if1.gnt1, u_if1.sel, u_if1.busy}, 4'b0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        apply(a, b);
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp4.size() > 0) begin
                e = q_exp4.pop_front();
                check("grant_mb4", {u_if4.gnt0, u_if4.gnt1, u_if4.sel, u_if4.busy}, e);
            end
            if (q_exp1.size() > 0) begin
                e = q_exp1.pop_front();
                check("grant_mb1", {u_if1.gnt0, u_if1.gnt1, u_if1.sel, u_if1.busy}, e);
            end
        end
    end

    initial begin : stimulus
        u_if4.req0 = 1'b0;
        u_if4.req1 = 1'b0;
        u_if1.req0 = 1'b0;
        u_if1.req1 = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("reset_mb4", {u_if4.gnt0, u_if4.gnt1, u_if4.sel, u_if4.busy}, 4'b0000);
        check("reset_mb1", {u_if1.gnt0, u_if1.gnt1, u_if1.sel, u_if1.busy}, 4'b0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(1'b0, 1'b0);

        // single request on side 1, then release: sel must stay 1 in idle
        cycn(3, 1'b0, 1'b1);
        cycn(2, 1'b0, 1'b0);
        // reset while sel=1, then first tie goes to requester 0 and contention runs 20 cycles
        do_reset(1'b1, 1'b1);
        cycn(20, 1'b1, 1'b1);
        cycn(2, 1'b0, 1'b0);
        // bubble-free handover when the owner drops while the other waits
        cyc(1'b1, 1'b0);
        cycn(2, 1'b1, 1'b1);
        cycn(2, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        // uncontended long hold, then contention after saturation
        cycn(10, 1'b1, 1'b0);
        cycn(6, 1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        // reset in the middle of an OWN1 grant with both requesting
        cycn(2, 1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        do_reset(1'b1, 1'b1);
        cycn(3, 1'b1, 1'b1);
        cyc(1'b0, 1'b0);

        // randomized request hold/toggle traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic a;
            logic b;
            a = ($urandom_range(3) == 0) ? !cur_a : cur_a;
            b = ($urandom_range(3) == 0) ? !cur_b : cur_b;
            if ($urandom_range(99) == 0) do_reset(a, b);
            else                         cyc(a, b);
        end
        cycn(2, 1'b0, 1'b0);

        @(posedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
